// File: rtl/pe_demux_stream.sv
// ---------------------------------------------------------------------------
// pe_demux_stream
//   Steers one signed PE output stream to either the raw path (branch A) or
//   the activation path (branch B), chosen per beat by in_sel. Each branch
//   owns a small FIFO so a stalled consumer only blocks beats that select it.
//   Per-branch accepted-beat counters are exported for debug/perf readout.
//
// Handshake rule (all three interfaces): a beat transfers on a rising clk
// edge where valid && ready are both high. valid never waits on ready, and
// in_ready never looks at in_valid, a_ready or b_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_sel              0 -> branch A (raw), 1 -> branch B (activation)
//   in_data [W]         signed input beat
//   a_valid/a_ready     branch A head handshake, a_data [W] head data
//   b_valid/b_ready     branch B head handshake, b_data [W] head data
//   cnt_a/cnt_b [CNT_W] beats accepted into each branch since reset (wraps)
// ---------------------------------------------------------------------------

// Per-branch FIFO. The head is kept in its own register so it is valid one
// cycle after the push and holds its last value once the FIFO drains.
// The caller must not push when full nor pop when empty.
module pe_demux_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] head_q, head_d;

  // Same index with differing wrap bits means full.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    // Pre-load the head register with what the head will be next cycle;
    // leave it alone when the FIFO will be empty so data holds.
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module pe_demux_stream #(
  parameter int W     = 24,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sel,
  input  logic signed [W-1:0] in_data,
  output logic                a_valid,
  input  logic                a_ready,
  output logic signed [W-1:0] a_data,
  output logic                b_valid,
  input  logic                b_ready,
  output logic signed [W-1:0] b_data,
  output logic [CNT_W-1:0]    cnt_a,
  output logic [CNT_W-1:0]    cnt_b
);
  logic full_a, empty_a, full_b, empty_b;
  logic push_a, push_b, pop_a, pop_b, accept;
  logic [W-1:0] head_a, head_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  // Ready comes only from the registered full flags, so a full branch with
  // its consumer ready takes a new beat one cycle after the pop.
  assign in_ready = in_sel ? !full_b : !full_a;
  assign accept   = in_valid && in_ready;
  assign push_a   = accept && !in_sel;
  assign push_b   = accept &&  in_sel;

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;
  assign pop_a   = a_valid && a_ready;
  assign pop_b   = b_valid && b_ready;
  assign a_data  = head_a;
  assign b_data  = head_b;

  pe_demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .pop       (pop_a),
    .full      (full_a),
    .empty     (empty_a),
    .head      (head_a)
  );

  pe_demux_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .pop       (pop_b),
    .full      (full_b),
    .empty     (empty_b),
    .head      (head_b)
  );

  always_comb begin
    cnt_a_d = cnt_a_q + CNT_W'(push_a);
    cnt_b_d = cnt_b_q + CNT_W'(push_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
endmodule
